// File: rtl/lsu_mem_adapter_if.sv
// Bus bundle between the pipeline/memory environment (master) and the MIPS32 load/store adapter (slave).
// The master side also drives mem_rdata because the async-read memory lives with the environment.
interface lsu_mem_adapter_if #(
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_exc;
    logic [31:0]           resp_badvaddr;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [ADDR_WIDTH-1:0] dw_addr;
    logic [DATA_WIDTH-1:0] dw_data;
    logic [3:0]            dw_mask;
    logic                  dw_en;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_exc, resp_badvaddr,
        input  mem_addr, dw_addr, dw_data, dw_mask, dw_en
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_exc, resp_badvaddr,
        output mem_addr, dw_addr, dw_data, dw_mask, dw_en
    );
endinterface

// File: rtl/lsu_mem_adapter.sv
// MIPS32 load/store adapter: alignment check, word-aligned memory access with byte lanes,
// load extraction with sign/zero extension, and one registered response per request.
module lsu_mem_adapter #(
    parameter int NUM_BYTES  = 1 << 21,
    parameter int DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    lsu_mem_adapter_if.slave  bus
);
    localparam int ADDR_WIDTH = $clog2(NUM_BYTES);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_q;
    logic                  reqReady_q;
    logic                  respValid_q;
    logic                  respExc_q;
    logic [DATA_WIDTH-1:0] respRdata_q;
    logic [31:0]           respBadvaddr_q;
    logic [ADDR_WIDTH-1:0] memAddr_q;
    logic [ADDR_WIDTH-1:0] dwAddr_q;
    logic [DATA_WIDTH-1:0] dwData_q;
    logic [3:0]            dwMask_q;
    logic                  dwEn_q;
    logic                  we_q;
    logic                  unsigned_q;
    logic [1:0]            size_q;
    logic [1:0]            addrLo_q;

    logic                  alignOk_d;
    logic [3:0]            mask_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [DATA_WIDTH-1:0] loadData_d;
    logic [7:0]            loadByte;
    logic [15:0]           loadHalf;

    always_comb begin
        alignOk_d = 1'b0;
        mask_d    = 4'b1111;
        wdata_d   = bus.req_wdata;
        case (bus.req_size)
            2'd0: begin
                alignOk_d = 1'b1;
                mask_d    = 4'b0001 << bus.req_addr[1:0];
                wdata_d   = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                alignOk_d = ~bus.req_addr[0];
                mask_d    = 4'b0011 << bus.req_addr[1:0];
                wdata_d   = {2{bus.req_wdata[15:0]}};
            end
            2'd2:    alignOk_d = (bus.req_addr[1:0] == 2'b00);
            default: alignOk_d = 1'b0;
        endcase
    end

    // Load lane selection works on the latched low address bits and the live async read data.
    always_comb begin
        loadByte   = bus.mem_rdata[7:0];
        loadHalf   = addrLo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        loadData_d = bus.mem_rdata;
        case (addrLo_q)
            2'd0:    loadByte = bus.mem_rdata[7:0];
            2'd1:    loadByte = bus.mem_rdata[15:8];
            2'd2:    loadByte = bus.mem_rdata[23:16];
            default: loadByte = bus.mem_rdata[31:24];
        endcase
        case (size_q)
            2'd0:    loadData_d = unsigned_q ? {24'd0, loadByte} : {{24{loadByte[7]}}, loadByte};
            2'd1:    loadData_d = unsigned_q ? {16'd0, loadHalf} : {{16{loadHalf[15]}}, loadHalf};
            default: loadData_d = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            reqReady_q     <= 1'b1;
            respValid_q    <= 1'b0;
            respExc_q      <= 1'b0;
            respRdata_q    <= '0;
            respBadvaddr_q <= '0;
            memAddr_q      <= '0;
            dwAddr_q       <= '0;
            dwData_q       <= '0;
            dwMask_q       <= '0;
            dwEn_q         <= 1'b0;
            we_q           <= 1'b0;
            unsigned_q     <= 1'b0;
            size_q         <= 2'd0;
            addrLo_q       <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q       <= bus.req_we;
                        size_q     <= bus.req_size;
                        unsigned_q <= bus.req_unsigned;
                        addrLo_q   <= bus.req_addr[1:0];
                        reqReady_q <= 1'b0;
                        if (alignOk_d) begin
                            state_q   <= ACCESS;
                            memAddr_q <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                            dwAddr_q  <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                            if (bus.req_we) begin
                                dwEn_q   <= 1'b1;
                                dwMask_q <= mask_d;
                                dwData_q <= wdata_d;
                            end
                        end else begin
                            state_q        <= RESP;
                            respValid_q    <= 1'b1;
                            respExc_q      <= 1'b1;
                            respBadvaddr_q <= bus.req_addr;
                            respRdata_q    <= '0;
                        end
                    end
                end
                ACCESS: begin
                    state_q        <= RESP;
                    respValid_q    <= 1'b1;
                    respExc_q      <= 1'b0;
                    respBadvaddr_q <= '0;
                    respRdata_q    <= we_q ? '0 : loadData_d;
                    memAddr_q      <= '0;
                    dwAddr_q       <= '0;
                    dwData_q       <= '0;
                    dwMask_q       <= '0;
                    dwEn_q         <= 1'b0;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_q        <= IDLE;
                        reqReady_q     <= 1'b1;
                        respValid_q    <= 1'b0;
                        respExc_q      <= 1'b0;
                        respRdata_q    <= '0;
                        respBadvaddr_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The write strobe is squashed while reset is high so an interrupted store never reaches memory.
    assign bus.dw_en         = dwEn_q & ~reset;
    assign bus.dw_mask       = reset ? 4'b0000 : dwMask_q;
    assign bus.dw_addr       = dwAddr_q;
    assign bus.dw_data       = dwData_q;
    assign bus.mem_addr      = memAddr_q;
    assign bus.req_ready     = reqReady_q;
    assign bus.resp_valid    = respValid_q;
    assign bus.resp_exc      = respExc_q;
    assign bus.resp_rdata    = respRdata_q;
    assign bus.resp_badvaddr = respBadvaddr_q;
endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Bench for lsu_mem_adapter: a small byte-masked memory, directed load/store requests,
// and a response scoreboard filled at accept time and drained when responses are taken.
module tb_lsu_mem_adapter;
    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    lsu_mem_adapter_if #(.ADDR_WIDTH(21), .DATA_WIDTH(32)) bus();

    lsu_mem_adapter #(.NUM_BYTES(1 << 21), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        exc;
        logic [31:0] bad;
    } respT;

    respT expQ[$];
    respT monExp;
    int   checkCount = 0;
    int   errCount   = 0;

    logic [31:0] memArr [0:1023];

    assign bus.mem_rdata = memArr[bus.mem_addr[11:2]];

    always @(posedge clk) begin
        if (bus.dw_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.dw_mask[b]) memArr[bus.dw_addr[11:2]][8*b +: 8] <= bus.dw_data[8*b +: 8];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Every taken response is matched against the oldest expectation pushed at accept time.
    always @(negedge clk) begin
        if (!reset && bus.resp_valid && bus.resp_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedResp", {31'd0, bus.resp_valid}, 32'd0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("respRdata", bus.resp_rdata, monExp.rdata);
                checkOutput("respExc", {31'd0, bus.resp_exc}, {31'd0, monExp.exc});
                checkOutput("respBadvaddr", bus.resp_badvaddr, monExp.bad);
            end
        end
    end

    task automatic applyStimulus(
        input string       name,
        input logic        we,
        input logic [1:0]  size,
        input logic        uns,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [31:0] expRdata,
        input logic        expExc,
        input logic [3:0]  expMask,
        input logic [31:0] expData,
        input logic [31:0] expAddr,
        input bit          stall
    );
        respT e;
        int   cyc = 0;
        int   dwCount = 0;
        bit   seen = 0;
        $display("[TB] %s", name);
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        if (stall) bus.resp_ready = 1'b0;
        checkOutput("reqReady", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        // Scramble the request fields so only latched values can produce the right answer.
        bus.req_valid    = 1'b0;
        bus.req_we       = ~we;
        bus.req_size     = 2'd3;
        bus.req_unsigned = ~uns;
        bus.req_addr     = 32'h0000_0001;
        bus.req_wdata    = $urandom;
        e.rdata = expRdata;
        e.exc   = expExc;
        e.bad   = expExc ? addr : 32'd0;
        expQ.push_back(e);
        while (!seen && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (bus.dw_en) begin
                dwCount++;
                checkOutput("dwMask", {28'd0, bus.dw_mask}, {28'd0, expMask});
                checkOutput("dwData", bus.dw_data, expData);
                checkOutput("dwAddr", {11'd0, bus.dw_addr}, expAddr);
            end else begin
                checkOutput("dwMaskIdle", {28'd0, bus.dw_mask}, 32'd0);
            end
            if (bus.resp_valid) seen = 1;
        end
        checkOutput("respValid", {31'd0, bus.resp_valid}, 32'd1);
        checkOutput("latency", cyc, expExc ? 32'd1 : 32'd2);
        checkOutput("dwPulses", dwCount, (we && !expExc) ? 32'd1 : 32'd0);
        if (stall) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                checkOutput("stallValid", {31'd0, bus.resp_valid}, 32'd1);
                checkOutput("stallRdata", bus.resp_rdata, expRdata);
                checkOutput("stallReady", {31'd0, bus.req_ready}, 32'd0);
            end
            @(posedge clk);
            #1;
            bus.resp_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) memArr[i] = 32'd0;
        memArr[32'h200 >> 2] = 32'h1122_3344;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        bus.resp_ready   = 1'b1;
        reset            = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rstReqReady", {31'd0, bus.req_ready}, 32'd1);
        checkOutput("rstRespValid", {31'd0, bus.resp_valid}, 32'd0);
        checkOutput("rstDwEn", {31'd0, bus.dw_en}, 32'd0);
        checkOutput("rstDwMask", {28'd0, bus.dw_mask}, 32'd0);
        checkOutput("rstRdata", bus.resp_rdata, 32'd0);

        applyStimulus("SW 0x100", 1, 2'd2, 0, 32'h100, 32'hDEAD_BEEF, 32'd0, 0, 4'hF, 32'hDEAD_BEEF, 32'h100, 0);
        applyStimulus("LW 0x100", 0, 2'd2, 0, 32'h100, 32'd0, 32'hDEAD_BEEF, 0, 4'h0, 32'd0, 32'd0, 0);
        applyStimulus("SB 0x103", 1, 2'd0, 0, 32'h103, 32'h0000_00A5, 32'd0, 0, 4'b1000, 32'hA5A5_A5A5, 32'h100, 0);
        applyStimulus("LB 0x103", 0, 2'd0, 0, 32'h103, 32'd0, 32'hFFFF_FFA5, 0, 4'h0, 32'd0, 32'd0, 0);
        applyStimulus("LBU 0x103", 0, 2'd0, 1, 32'h103, 32'd0, 32'h0000_00A5, 0, 4'h0, 32'd0, 32'd0, 0);
        applyStimulus("LH 0x100", 0, 2'd1, 0, 32'h100, 32'd0, 32'hFFFF_BEEF, 0, 4'h0, 32'd0, 32'd0, 0);
        applyStimulus("SH 0x102", 1, 2'd1, 0, 32'h102, 32'h0000_7E12, 32'd0, 0, 4'b1100, 32'h7E12_7E12, 32'h100, 0);
        applyStimulus("LH 0x102", 0, 2'd1, 0, 32'h102, 32'd0, 32'h0000_7E12, 0, 4'h0, 32'd0, 32'd0, 0);
        applyStimulus("LH 0x101 misaligned", 0, 2'd1, 0, 32'h101, 32'd0, 32'd0, 1, 4'h0, 32'd0, 32'd0, 0);
        applyStimulus("SW 0x102 misaligned", 1, 2'd2, 0, 32'h102, 32'h1234_5678, 32'd0, 1, 4'h0, 32'd0, 32'd0, 0);
        applyStimulus("size 3 at 0x104", 0, 2'd3, 0, 32'h104, 32'd0, 32'd0, 1, 4'h0, 32'd0, 32'd0, 0);
        applyStimulus("LBU 0x203", 0, 2'd0, 1, 32'h203, 32'd0, 32'h0000_0011, 0, 4'h0, 32'd0, 32'd0, 0);
        applyStimulus("LW 0x200200 wraps", 0, 2'd2, 0, 32'h0020_0200, 32'd0, 32'h1122_3344, 0, 4'h0, 32'd0, 32'd0, 0);
        applyStimulus("SW 0x100 pattern", 1, 2'd2, 0, 32'h100, 32'h8001_1234, 32'd0, 0, 4'hF, 32'h8001_1234, 32'h100, 0);
        applyStimulus("LHU 0x102 stalled", 0, 2'd1, 1, 32'h102, 32'd0, 32'h0000_8001, 0, 4'h0, 32'd0, 32'd0, 1);

        $display("[TB] reset during ACCESS of SW 0x200");
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h200;
        bus.req_wdata = 32'hCAFE_F00D;
        checkOutput("reqReady", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        checkOutput("rstAccessDwEn", {31'd0, bus.dw_en}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("postRstRespValid", {31'd0, bus.resp_valid}, 32'd0);
            checkOutput("postRstDwEn", {31'd0, bus.dw_en}, 32'd0);
            checkOutput("postRstReqReady", {31'd0, bus.req_ready}, 32'd1);
        end
        applyStimulus("LW 0x200 after reset", 0, 2'd2, 0, 32'h200, 32'd0, 32'h1122_3344, 0, 4'h0, 32'd0, 32'd0, 0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule

// File: doc/lsu_mem_adapter.md
Name: lsu_mem_adapter

Overview:
- MIPS32 load/store adapter between the pipeline's memory stage and the asynchronous-read, byte-masked-write emulator memory.
- Accepts one load/store request per handshake and checks alignment.
- Drives the word-aligned memory address and byte mask, then extracts and sign/zero-extends load data.
- Returns one registered response per request through a valid/ready handshake.

Parameters:
- NUM_BYTES, 1<<21, memory size in bytes; ADDR_WIDTH = $clog2(NUM_BYTES).
- DATA_WIDTH, 32, memory word width; fixed at 32 for this block.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  adapter can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  in  1  zero-extend loads (LBU/LHU).
- req_addr  in  32  byte virtual address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  32  extended load data; 0 for stores and exceptions.
- resp_exc  out  1  address error.
- resp_badvaddr  out  32  faulting address; 0 when no exception.
- mem_addr  out  ADDR_WIDTH  async read-port address, always word-aligned.
- mem_rdata  in  32  async read data for mem_addr, little-endian bytes.
- dw_addr  out  ADDR_WIDTH  write address, word-aligned.
- dw_data  out  32  write data, lane-shifted.
- dw_mask  out  4  byte-lane write enables.
- dw_en  out  1  write strobe, one cycle per store.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset forces IDLE.
- Reset values:
  - req_ready = 1 (IDLE).
  - resp_valid, resp_exc, dw_en = 0.
  - dw_mask = 0.
  - resp_rdata, resp_badvaddr, mem_addr, dw_addr, dw_data = 0.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we/size/unsigned/addr/wdata.
  - Alignment is legal when: size 0 any address; size 1 needs addr[0] = 0; size 2 needs addr[1:0] = 0.
  - Illegal alignment or size 3: skip memory, go to RESP with resp_exc = 1, resp_badvaddr = req_addr, resp_rdata = 0.
  - Legal: go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_addr = dw_addr = {latched_addr[ADDR_WIDTH-1:2], 2'b00}. Upper address bits beyond ADDR_WIDTH are ignored (wrap).
  - Store:
    - dw_en = 1.
    - dw_mask: byte = 4'b0001 << addr[1:0]; half = 4'b0011 << addr[1:0]; word = 4'b1111.
    - dw_data = wdata replicated per lane: byte → {4{b}}, half → {2{h}}, word → w.
    - resp_rdata = 0.
  - Load:
    - dw_en = 0.
    - Sample mem_rdata at the clock edge and select lane by addr[1:0]: byte = rdata[8*a +: 8]; half = rdata[16*a[1] +: 16].
    - Sign-extend unless req_unsigned; register result into resp_rdata.
  - Next state: RESP with resp_exc = 0.
- RESP:
  - resp_valid = 1; outputs stable until resp_ready.
  - On resp_ready: go to IDLE.
  - No request is accepted in RESP; there is no same-cycle IDLE bypass.
- Latency:
  - Legal access: accept at edge N, dw_en/read during cycle N+1, resp_valid from cycle N+2.
  - Exception: resp_valid from cycle N+1.
- Throughput: at most one request per 3 cycles.
- dw_en, dw_mask, dw_data and dw_addr are asserted only in ACCESS; dw_en = 0 and dw_mask = 0 in every other state.
- Reset asserted mid-operation (ACCESS or RESP): next state IDLE, no write issued on that edge, pending response discarded.
- resp_ready held high while idle has no effect.
- req_valid dropped while ACCESS/RESP is pending is ignored; request fields are used only as latched.

Test Plan:
- Reset held 2 cycles, then released → req_ready = 1, resp_valid = 0, dw_en = 0, dw_mask = 0.
- SW addr 0x100, wdata 0xDEADBEEF, then LW 0x100 → one dw_en pulse with mask 4'hF, dw_addr 0x100; load resp_rdata = 0xDEADBEEF, resp_exc = 0, resp_valid 2 cycles after accept.
- SB addr 0x103, wdata 0x000000A5, then LB 0x103 / LBU 0x103 → mask 4'b1000, dw_data 0xA5A5A5A5; LB returns 0xFFFFFFA5, LBU returns 0x000000A5.
- LH addr 0x101 and SW addr 0x102 → resp_exc = 1, resp_badvaddr 0x101 / 0x102, dw_en never asserted, resp_valid 1 cycle after accept.
- resp_ready held low 5 cycles during a LHU 0x102 over word 0x8001_1234 → resp_valid and resp_rdata 0x00008001 stable throughout, req_ready = 0 throughout; accept occurs after resp_ready rises.
- Reset pulsed during ACCESS of SW 0x200 → no dw_en pulse, no response; a later LW 0x200 returns the prior memory contents.
